// File: rtl/mod_counter_pkg.sv
// Shared constants and elaboration-time helpers for the modulo counter family.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit modulo_ok(input int width, input int modulo);
    return (modulo >= 2) && (longint'(modulo) <= (longint'(1) << width));
  endfunction

  function automatic bit prescale_ok(input int prescale);
    return prescale >= 1;
  endfunction

  function automatic bit reset_val_ok(input int reset_val, input int modulo);
    return (reset_val >= 0) && (reset_val < modulo);
  endfunction

endpackage

// File: rtl/mod_counter_tick_gen.sv
// Prescaler: emits tick on the enabled cycle that completes a PRESCALE-long period.
module tick_gen
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // PRESCALE=1 keeps a 1-bit pc that never leaves 0, so tick degenerates to en.
  localparam int PCW = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] PC_MAX = PCW'(PRESCALE - 1);

  logic [PCW-1:0] pc;

  assign tick = en && (pc == PC_MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) pc <= '0;
    else if (en)      pc <= tick ? '0 : pc + 1'b1;
  end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with prescaler, clamped load, tc pulse and sticky ovf.
// Define MOD_COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MODULO    = 256,
  parameter int PRESCALE  = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] value,
  output logic             tc,
  output logic             ovf
);

  if (!modulo_ok(WIDTH, MODULO)) begin : g_bad_modulo
    $error("mod_counter: MODULO must be in 2..2**WIDTH");
  end
  if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
    $error("mod_counter: PRESCALE must be >= 1");
  end
  if (!reset_val_ok(RESET_VAL, MODULO)) begin : g_bad_reset_val
    $error("mod_counter: RESET_VAL must be < MODULO");
  end

  // One extra bit so MODULO = 2**WIDTH needs no special case.
  localparam int AW = WIDTH + 1;
  localparam logic [AW-1:0] MAX = AW'(MODULO - 1);

  logic          step;
  logic [AW-1:0] v_ext;
  logic [AW-1:0] ld_ext;
  logic          at_limit;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tick  (step)
  );

  assign v_ext    = {1'b0, value};
  assign ld_ext   = {1'b0, load_val};
  assign at_limit = (up_dn == DIR_DN) ? (v_ext == '0) : (v_ext == MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= WIDTH'(RESET_VAL);
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr_ovf) ovf <= 1'b0;
      if (load) begin
        value <= (ld_ext > MAX) ? MAX[WIDTH-1:0] : load_val;
      end else if (step) begin
        if (at_limit) begin
          tc  <= 1'b1;
          ovf <= 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
          value <= value;
`else
          value <= (up_dn == DIR_UP) ? '0 : MAX[WIDTH-1:0];
`endif
        end else begin
          value <= (up_dn == DIR_UP) ? WIDTH'(v_ext + 1'b1) : WIDTH'(v_ext - 1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench: two counters (PRESCALE 1 and 3, MODULO 10) sharing one stimulus.
module tb_mod_counter;

`ifdef MOD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b1;
  logic       reset, en, up_dn, load, clr_ovf;
  logic [7:0] load_val;
  logic [7:0] v1, v3;
  logic       tc1, tc3, ovf1, ovf3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8), .MODULO(10), .PRESCALE(1), .RESET_VAL(0)) d1 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .value(v1), .tc(tc1), .ovf(ovf1)
  );

  mod_counter #(.WIDTH(8), .MODULO(10), .PRESCALE(3), .RESET_VAL(0)) d3 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .value(v3), .tc(tc3), .ovf(ovf3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input int v, input int t, input int o);
    chk({tag, ".value"}, int'(v1), v);
    chk({tag, ".tc"},    int'(tc1), t);
    chk({tag, ".ovf"},   int'(ovf1), o);
  endtask

  task automatic chk3(input string tag, input int v, input int t, input int o);
    chk({tag, ".value"}, int'(v3), v);
    chk({tag, ".tc"},    int'(tc3), t);
    chk({tag, ".ovf"},   int'(ovf3), o);
  endtask

  // Called at edge+1: reset rises at edge+7 and covers exactly the edge at +10.
  task automatic rst_pulse(input int len);
    #6;
    reset = 1'b1;
    #(len);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'd0; clr_ovf = 1'b0;
    tick();
    chk1("rst_d1", 0, 0, 0);
    chk3("rst_d3", 0, 0, 0);
    reset = 1'b0;

    // PRESCALE=1 up count 0..9 then wrap
    en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i < 10) chk1($sformatf("up%0d", i), i, 0, 0);
      else        chk1("up_wrap", SAT ? 9 : 0, 1, 1);
    end
    tick();
    chk1("after_wrap", SAT ? 9 : 1, SAT ? 1 : 0, 1);
    en = 1'b0; clr_ovf = 1'b1;
    tick();
    chk1("clr_ovf", SAT ? 9 : 1, 0, 0);
    clr_ovf = 1'b0;

    // clr_ovf on the wrap edge: set wins
    load = 1'b1; load_val = 8'd9;
    tick();
    chk1("load9", 9, 0, 0);
    load = 1'b0; en = 1'b1; clr_ovf = 1'b1;
    tick();
    chk1("wrap_vs_clr", SAT ? 9 : 0, 1, 1);
    en = 1'b0;
    tick();
    chk1("clr_next", SAT ? 9 : 0, 0, 0);
    clr_ovf = 1'b0;

    // down from 0
    load = 1'b1; load_val = 8'd0;
    tick();
    chk1("load0", 0, 0, 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    chk1("dn_wrap", SAT ? 0 : 9, 1, 1);
    tick();
    chk1("dn_next", SAT ? 0 : 8, SAT ? 1 : 0, 1);
    en = 1'b0;

    // clamped load, ovf unaffected
    load = 1'b1; load_val = 8'd12;
    tick();
    chk1("load12_clamp", 9, 0, 1);

    // load beats step on the same edge, and clears the prescaler
    en = 1'b1; load_val = 8'd4;
    tick();
    chk1("load4_en", 4, 0, 1);
    chk("load4_en.d3", int'(v3), 4);
    load = 1'b0; up_dn = 1'b1;
    tick();
    chk1("post_load_d1", 5, 0, 1);
    chk("post_load_d3a", int'(v3), 4);
    tick();
    chk("post_load_d3b", int'(v3), 4);
    tick();
    chk("post_load_d3c", int'(v3), 5);

    // PRESCALE=3 with an en gap of two cycles
    reset = 1'b1; en = 1'b0;
    tick();
    chk3("rst2", 0, 0, 0);
    reset = 1'b0; en = 1'b1;
    tick(); chk("ps_c1", int'(v3), 0);
    tick(); chk("ps_c2", int'(v3), 0);
    tick(); chk3("ps_c3", 1, 0, 0);
    tick(); chk("ps_c4", int'(v3), 1);
    en = 1'b0;
    tick(); chk("ps_gap1", int'(v3), 1);
    tick(); chk("ps_gap2", int'(v3), 1);
    en = 1'b1;
    tick(); chk("ps_c5", int'(v3), 1);
    tick(); chk3("ps_c6", 2, 0, 0);

    // wrap d3 so ovf is set, then reset mid-count
    en = 1'b0; load = 1'b1; load_val = 8'd9;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); tick(); tick();
    chk3("d3_wrap", SAT ? 9 : 0, 1, 1);
    rst_pulse(11);
    chk3("rst_pulse11", 0, 0, 0);
    chk1("rst_pulse11_d1", 0, 0, 0);
    tick(); chk("rst11_c1", int'(v3), 0);
    tick(); chk("rst11_c2", int'(v3), 0);
    tick(); chk("rst11_c3", int'(v3), 1);
    tick(); chk("rst11_c4", int'(v3), 1);
    rst_pulse(5);
    chk3("rst_pulse5", 0, 0, 0);
    tick(); chk("rst5_c1", int'(v3), 0);
    tick(); chk("rst5_c2", int'(v3), 0);
    tick(); chk3("rst5_c3", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
